// File: rtl/rgb565_gray.sv
// RGB565 to 8-bit luminance front end for the Sobel path.
// The design is a three-stage valid-tagged pipeline with raster position markers
// and a sticky frame-alignment error flag.
// Optional feature: define GRAY_ROUND_EN for round-half-up luminance. When it is
// undefined, the luminance is truncated.
module rgb565_gray #(
  parameter int unsigned H_PIXEL = 640,
  parameter int unsigned V_PIXEL = 480
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        pi_flag,
  input  logic [15:0] pi_data,
  input  logic        pi_sof,
  output logic        po_flag,
  output logic [7:0]  po_gray,
  output logic [15:0] po_data,
  output logic        po_sol,
  output logic        po_eol,
  output logic        po_eof,
  output logic        frame_err
);

  localparam int unsigned HW = (H_PIXEL > 1) ? $clog2(H_PIXEL) : 1;
  localparam int unsigned VW = (V_PIXEL > 1) ? $clog2(V_PIXEL) : 1;
  localparam logic [HW-1:0] HLast = HW'(H_PIXEL - 1);
  localparam logic [VW-1:0] VLast = VW'(V_PIXEL - 1);

`ifdef GRAY_ROUND_EN
  localparam logic [15:0] RoundAdd = 16'd128;
`else
  localparam logic [15:0] RoundAdd = 16'd0;
`endif

  // Raster counters and error flag
  logic [HW-1:0] cnt_h_q, cnt_h_d;
  logic [VW-1:0] cnt_v_q, cnt_v_d;
  logic          frame_err_q, frame_err_d;

  // Stage 1: weighted channel products
  logic          valid1_q, valid1_d;
  logic [15:0]   prod_r_q, prod_r_d;
  logic [15:0]   prod_g_q, prod_g_d;
  logic [15:0]   prod_b_q, prod_b_d;
  logic [2:0]    tags1_q, tags1_d;   // {sol, eol, eof}

  // Stage 2: luminance byte (upper byte of the weighted sum)
  logic          valid2_q, valid2_d;
  logic [7:0]    sum_hi_q, sum_hi_d;
  logic [2:0]    tags2_q, tags2_d;

  // Stage 3: output registers
  logic          po_flag_q, po_flag_d;
  logic [7:0]    po_gray_q, po_gray_d;
  logic [15:0]   po_data_q, po_data_d;
  logic          po_sol_q, po_sol_d;
  logic          po_eol_q, po_eol_d;
  logic          po_eof_q, po_eof_d;

  // Position of the incoming pixel: SOF forces (0,0) regardless of the counters
  logic [HW-1:0] pos_h;
  logic [VW-1:0] pos_v;
  logic          tag_sol, tag_eol, tag_eof;
  logic [7:0]    r8, g8, b8;

  // Input-side position, raster counter advance and frame-alignment check
  always_comb begin
    pos_h       = pi_sof ? '0 : cnt_h_q;
    pos_v       = pi_sof ? '0 : cnt_v_q;
    tag_sol     = (pos_h == '0);
    tag_eol     = (pos_h == HLast);
    tag_eof     = tag_eol && (pos_v == VLast);
    cnt_h_d     = cnt_h_q;
    cnt_v_d     = cnt_v_q;
    frame_err_d = frame_err_q;
    if (pi_flag) begin
      if (tag_eol) begin
        cnt_h_d = '0;
        cnt_v_d = (pos_v == VLast) ? '0 : pos_v + VW'(1);
      end else begin
        cnt_h_d = pos_h + HW'(1);
        cnt_v_d = pos_v;
      end
      if (pi_sof && ((cnt_h_q != '0) || (cnt_v_q != '0))) begin
        frame_err_d = 1'b1;
      end
    end
  end

  // Stage 1: expand channels to 8 bits and weight them; data holds across bubbles
  always_comb begin
    r8       = {pi_data[15:11], pi_data[15:13]};
    g8       = {pi_data[10:5], pi_data[10:9]};
    b8       = {pi_data[4:0], pi_data[4:2]};
    valid1_d = pi_flag;
    tags1_d  = {tag_sol, tag_eol, tag_eof};
    prod_r_d = prod_r_q;
    prod_g_d = prod_g_q;
    prod_b_d = prod_b_q;
    if (pi_flag) begin
      prod_r_d = 16'(r8) * 16'd77;
      prod_g_d = 16'(g8) * 16'd150;
      prod_b_d = 16'(b8) * 16'd29;
    end
  end

  // Stage 2: sum of products (max 65280, plus optional rounding bias, fits 16 bits)
  always_comb begin
    valid2_d = valid1_q;
    tags2_d  = tags1_q;
    sum_hi_d = 8'((prod_r_q + prod_g_q + prod_b_q + RoundAdd) >> 8);
  end

  // Stage 3: outputs; markers only qualify valid pixels
  always_comb begin
    po_flag_d = valid2_q;
    po_gray_d = sum_hi_q;
    po_data_d = {sum_hi_q[7:3], sum_hi_q[7:2], sum_hi_q[7:3]};
    po_sol_d  = valid2_q & tags2_q[2];
    po_eol_d  = valid2_q & tags2_q[1];
    po_eof_d  = valid2_q & tags2_q[0];
  end

  // State registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_h_q     <= '0;
      cnt_v_q     <= '0;
      frame_err_q <= 1'b0;
      valid1_q    <= 1'b0;
      prod_r_q    <= '0;
      prod_g_q    <= '0;
      prod_b_q    <= '0;
      tags1_q     <= '0;
      valid2_q    <= 1'b0;
      sum_hi_q    <= '0;
      tags2_q     <= '0;
      po_flag_q   <= 1'b0;
      po_gray_q   <= '0;
      po_data_q   <= '0;
      po_sol_q    <= 1'b0;
      po_eol_q    <= 1'b0;
      po_eof_q    <= 1'b0;
    end else begin
      cnt_h_q     <= cnt_h_d;
      cnt_v_q     <= cnt_v_d;
      frame_err_q <= frame_err_d;
      valid1_q    <= valid1_d;
      prod_r_q    <= prod_r_d;
      prod_g_q    <= prod_g_d;
      prod_b_q    <= prod_b_d;
      tags1_q     <= tags1_d;
      valid2_q    <= valid2_d;
      sum_hi_q    <= sum_hi_d;
      tags2_q     <= tags2_d;
      po_flag_q   <= po_flag_d;
      po_gray_q   <= po_gray_d;
      po_data_q   <= po_data_d;
      po_sol_q    <= po_sol_d;
      po_eol_q    <= po_eol_d;
      po_eof_q    <= po_eof_d;
    end
  end

  assign po_flag   = po_flag_q;
  assign po_gray   = po_gray_q;
  assign po_data   = po_data_q;
  assign po_sol    = po_sol_q;
  assign po_eol    = po_eol_q;
  assign po_eof    = po_eof_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/rgb565_gray.md
# rgb565_gray

Front-end pixel stage of the edge-detection path: converts the RGB565 camera/DDR3 pixel stream to 8-bit luminance and presents it, together with raster position markers, to the Sobel stage directly downstream. Three-stage registered pipeline with valid tagging, horizontal/vertical raster counters and a sticky frame-alignment error flag. One pixel per clock maximum; no back-pressure.

## Interface
- H_PIXEL, 640, active pixels per line (counter wrap for cnt_h)
- V_PIXEL, 480, active lines per frame (counter wrap for cnt_v)
- sys_clk  in  1  single clock, all logic rising-edge
- sys_rst  in  1  synchronous, active-high reset
- pi_flag  in  1  input pixel valid
- pi_data  in  16  RGB565 pixel {R[15:11], G[10:5], B[4:0]}, sampled when pi_flag=1
- pi_sof  in  1  start-of-frame marker, qualified by pi_flag; marks the pixel as row 0, col 0
- po_flag  out  1  output pixel valid
- po_gray  out  8  luminance
- po_data  out  16  luminance re-packed as RGB565: {gray[7:3], gray[7:2], gray[7:3]}
- po_sol  out  1  with po_flag: pixel is column 0
- po_eol  out  1  with po_flag: pixel is column H_PIXEL-1
- po_eof  out  1  with po_flag: pixel is column H_PIXEL-1 of row V_PIXEL-1
- frame_err  out  1  sticky: pi_sof seen while counters not at (0,0)

## Operation
- Stage 1 (on pi_flag): expand to 8 bits: R8={R,R[4:2]}, G8={G,G[5:4]}, B8={B,B[4:2]}; register products 77·R8, 150·G8, 29·B8 (16 bits each). Register position tags derived from cnt_h/cnt_v.
- Stage 2: sum = sum of three products, 16-bit unsigned; max 65280, no overflow.
- Stage 3: gray = sum[15:8] (see Configuration); register po_gray, po_data, markers, po_flag.
- Valid bit travels with each pixel; bubbles on pi_flag propagate unchanged. Non-valid stages still clock but po_sol/po_eol/po_eof are forced 0 when po_flag=0.
- Raster counters advance on input side only when pi_flag=1: cnt_h 0..H_PIXEL-1, on wrap cnt_v increments; at (H_PIXEL-1, V_PIXEL-1) both wrap to 0.
- pi_sof with pi_flag: that pixel is (0,0); counters become (1,0) next. If counters were not (0,0) at that moment, frame_err sets and stays 1 until reset; the current pixel is still processed as (0,0).
- pi_sof without pi_flag: ignored.
- Frame without pi_sof: counters free-run and wrap; no error.

## Timing
- Latency: pixel with pi_flag=1 at cycle N appears with po_flag=1 at cycle N+3. Throughput 1 pixel/clock.
- Reset values: po_flag=0, po_gray=0, po_data=0, po_sol=0, po_eol=0, po_eof=0, frame_err=0; cnt_h=cnt_v=0.
- Reset mid-operation: all in-flight pixels discarded (no po_flag for them), counters zero, frame_err cleared, effective the cycle after sys_rst is sampled high.
- frame_err asserts the cycle after the offending pi_sof is sampled (not pipeline-delayed).
- Back-to-back frames: eof pixel followed immediately by sof pixel is legal, no error.

## Configuration
- GRAY_ROUND_EN defined: gray = (sum + 128) >> 8 (round-half-up; cannot exceed 255 since max sum+128 = 65408).
- Undefined: gray = sum >> 8 (truncation).
- Latency and all other behaviour identical in both builds.

## Test plan
- Reset: hold sys_rst 3 cycles with pi_flag=1 -> all outputs 0 during and 1 cycle after release; first po_flag exactly 3 cycles after first sampled pixel.
- Colour points: pi_data 0xFFFF -> po_gray 255, po_data 0xFFFF; 0xF800 -> 76 / 0x4A69 (77 with GRAY_ROUND_EN); 0x07E0 -> 149; 0x001F -> 28 (29 with GRAY_ROUND_EN); 0x0000 -> 0.
- Full 640x480 frame with pi_sof on first pixel and random 1-3 cycle gaps -> 307200 po_flag pulses, po_sol 480, po_eol 480, po_eof once on last pixel, frame_err 0, bubble pattern preserved at output.
- Early sof: pi_sof at pixel index 1000 of a frame -> frame_err=1 next cycle and sticky; that pixel emerges with po_sol=1; eol appears 639 pixels later.
- Reset mid-line after 100 pixels -> no output for in-flight pixels; next frame starts at (0,0) with frame_err 0.
- Back-to-back frames (H_PIXEL=4, V_PIXEL=2) with sof on each first pixel -> po_eof on pixels 8 and 16, frame_err stays 0.
